// File: rtl/pomo_scheduler.sv
// -----------------------------------------------------------------------------
// pomo_scheduler
//
// Session sequencer for an MM:SS countdown timer. Runs the classic
// work -> short break -> work ... -> long break cycle. For every phase it loads
// BCD preset digits into the timer, gates the timer run enable and watches the
// timer finish flag. User pause/skip/abort pulses are handled here, and phase,
// completed-cycle count and completion pulses are reported to display/LED logic.
//
// Build option:
//   AUTO_ADVANCE_EN  defined   -> after a work/short phase completes, the next
//                                 phase is loaded and started immediately.
//                    undefined -> the sequencer parks in HOLD showing the next
//                                 phase and waits for a start pulse.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   start          pulse: begin a session (IDLE) or resume from HOLD
//   pause          pulse: toggle RUN / PAUSE
//   skip           pulse: end the current phase now
//   abort          pulse: return to IDLE
//   tmr_finish     timer expired flag (level, may stay high)
//   tmr_load       one-cycle load strobe to the timer
//   tmr_min2..sec1 BCD preset digits (MM:SS)
//   tmr_run        timer count enable
//   phase          0=NONE 1=WORK 2=SHORT 3=LONG
//   cycle_cnt      completed work phases in the current session
//   phase_done     one-cycle pulse per completed or skipped phase
//   session_done   one-cycle pulse when the long break completes
// -----------------------------------------------------------------------------
module pomo_scheduler #(
  parameter int WORK_MIN        = 25,
  parameter int SHORT_MIN       = 5,
  parameter int LONG_MIN        = 15,
  parameter int CYCLES_PER_LONG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       skip,
  input  logic       abort,
  input  logic       tmr_finish,
  output logic       tmr_load,
  output logic [3:0] tmr_min2,
  output logic [3:0] tmr_min1,
  output logic [3:0] tmr_sec2,
  output logic [3:0] tmr_sec1,
  output logic       tmr_run,
  output logic [1:0] phase,
  output logic [2:0] cycle_cnt,
  output logic       phase_done,
  output logic       session_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_WORK  = 2'd1,
    PH_SHORT = 2'd2,
    PH_LONG  = 2'd3
  } phase_t;

  // Where a non-LONG completion goes next.
`ifdef AUTO_ADVANCE_EN
  localparam state_t AFTER_PHASE = S_LOAD;
`else
  localparam state_t AFTER_PHASE = S_HOLD;
`endif

  localparam logic [2:0] CYCLES_LONG = 3'(CYCLES_PER_LONG);

  // Minutes value -> {tens, units} BCD.
  function automatic logic [7:0] to_bcd(input int m);
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  localparam logic [7:0] WORK_BCD  = to_bcd(WORK_MIN);
  localparam logic [7:0] SHORT_BCD = to_bcd(SHORT_MIN);
  localparam logic [7:0] LONG_BCD  = to_bcd(LONG_MIN);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t     state,      state_next;
  phase_t     phase_q,    phase_next;
  logic [2:0] cycle_q,    cycle_next;
  logic [7:0] min_q,      min_next;
  logic       done_q,     done_next;
  logic       sess_q,     sess_next;
  logic       fin_q,      fin_next;

  logic       fin_edge;
  logic       complete;
  logic       go_idle;
  logic [2:0] cycle_inc;
  logic [7:0] preset_bcd;

  // A finish that was already high is never a new expiry; fin_q is forced
  // high during LOAD so a stale flag from the previous phase is absorbed.
  assign fin_edge  = tmr_finish & ~fin_q;
  assign cycle_inc = cycle_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_next = state;
    phase_next = phase_q;
    cycle_next = cycle_q;
    done_next  = 1'b0;
    sess_next  = 1'b0;
    complete   = 1'b0;
    go_idle    = 1'b0;
    fin_next   = (state == S_LOAD) ? 1'b1 : tmr_finish;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          phase_next = PH_WORK;
          cycle_next = 3'd0;
        end
      end

      S_LOAD: state_next = S_RUN;

      S_RUN: begin
        if (abort)                 go_idle    = 1'b1;
        else if (skip || fin_edge) complete   = 1'b1;
        else if (pause)            state_next = S_PAUSE;
      end

      S_PAUSE: begin
        if (abort)      go_idle    = 1'b1;
        else if (skip)  complete   = 1'b1;
        else if (pause) state_next = S_RUN;
      end

      S_HOLD: begin
        if (abort)      go_idle    = 1'b1;
        else if (start) state_next = S_LOAD;
      end

      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_next = S_IDLE;
      phase_next = PH_NONE;
      cycle_next = 3'd0;
    end

    if (complete) begin
      done_next = 1'b1;
      case (phase_q)
        PH_WORK: begin
          cycle_next = cycle_inc;
          phase_next = (cycle_inc == CYCLES_LONG) ? PH_LONG : PH_SHORT;
          state_next = AFTER_PHASE;
        end
        PH_SHORT: begin
          phase_next = PH_WORK;
          state_next = AFTER_PHASE;
        end
        PH_LONG: begin
          sess_next  = 1'b1;
          cycle_next = 3'd0;
          phase_next = PH_NONE;
          state_next = S_IDLE;
        end
        default: begin
          phase_next = PH_NONE;
          state_next = S_IDLE;
        end
      endcase
    end

    case (phase_next)
      PH_WORK:  preset_bcd = WORK_BCD;
      PH_SHORT: preset_bcd = SHORT_BCD;
      PH_LONG:  preset_bcd = LONG_BCD;
      default:  preset_bcd = 8'h00;
    endcase

    // Digits change only on entry to LOAD or on abort; a LONG completion
    // leaves the last preset visible.
    min_next = min_q;
    if (go_idle)
      min_next = 8'h00;
    else if (state_next == S_LOAD && state != S_LOAD)
      min_next = preset_bcd;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state   <= S_IDLE;
      phase_q <= PH_NONE;
      cycle_q <= 3'd0;
      min_q   <= 8'h00;
      done_q  <= 1'b0;
      sess_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state   <= state_next;
      phase_q <= phase_next;
      cycle_q <= cycle_next;
      min_q   <= min_next;
      done_q  <= done_next;
      sess_q  <= sess_next;
      fin_q   <= fin_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tmr_load     = (state == S_LOAD);
  assign tmr_run      = (state == S_RUN);
  assign tmr_min2     = min_q[7:4];
  assign tmr_min1     = min_q[3:0];
  assign tmr_sec2     = 4'd0;
  assign tmr_sec1     = 4'd0;
  assign phase        = phase_q;
  assign cycle_cnt    = cycle_q;
  assign phase_done   = done_q;
  assign session_done = sess_q;

endmodule

// File: tb/tb_pomo_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pomo_scheduler
//
// Directed bench for pomo_scheduler with WORK=25, SHORT=5, LONG=15 and two work
// phases per session. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, away from the active edge. Expected output
// vectors are written out by hand; builds with and without AUTO_ADVANCE_EN are
// both covered through the AUTO constant.
// -----------------------------------------------------------------------------
module tb_pomo_scheduler;

`ifdef AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       skip = 1'b0;
  logic       abort = 1'b0;
  logic       tmr_finish = 1'b0;
  logic       tmr_load;
  logic [3:0] tmr_min2, tmr_min1, tmr_sec2, tmr_sec1;
  logic       tmr_run;
  logic [1:0] phase;
  logic [2:0] cycle_cnt;
  logic       phase_done;
  logic       session_done;

  int errors = 0;
  int checks = 0;
  logic [24:0] e;

  pomo_scheduler #(
    .WORK_MIN(25),
    .SHORT_MIN(5),
    .LONG_MIN(15),
    .CYCLES_PER_LONG(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .skip(skip),
    .abort(abort),
    .tmr_finish(tmr_finish),
    .tmr_load(tmr_load),
    .tmr_min2(tmr_min2),
    .tmr_min1(tmr_min1),
    .tmr_sec2(tmr_sec2),
    .tmr_sec1(tmr_sec1),
    .tmr_run(tmr_run),
    .phase(phase),
    .cycle_cnt(cycle_cnt),
    .phase_done(phase_done),
    .session_done(session_done)
  );

  always #5 clk = ~clk;

  // Packed view: {load, run, phase, cycle_cnt, phase_done, session_done, digits}
  function automatic logic [24:0] obs();
    return {tmr_load, tmr_run, phase, cycle_cnt, phase_done, session_done,
            tmr_min2, tmr_min1, tmr_sec2, tmr_sec1};
  endfunction

  function automatic logic [24:0] ex(input logic ld, input logic run,
                                     input logic [1:0] ph, input logic [2:0] cn,
                                     input logic pd, input logic sd,
                                     input logic [15:0] dg);
    return {ld, run, ph, cn, pd, sd, dg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One RUN cycle with finish low, then a rising finish sampled on the next edge.
  task automatic fin_pulse();
    tmr_finish = 1'b0;
    tick();
    tmr_finish = 1'b1;
    tick();
    tmr_finish = 1'b0;
  endtask

  // From the cycle after a non-LONG completion: reach LOAD, check it, enter RUN.
  task automatic advance(input logic [1:0] ph, input logic [2:0] cn,
                         input logic [15:0] dg, input string name);
    if (!AUTO) pulse_start();
    e = ex(1'b1, 1'b0, ph, cn, AUTO, 1'b0, dg);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs(), e);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    e = '0;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), e);
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    do_reset();
    pulse_start();
    e = ex(1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL start_load: got %h expected %h", obs(), e);
    end
    tick();
    e = ex(1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL start_run: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_stale_finish();
    do_reset();
    tmr_finish = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    e = ex(1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL stale_finish_ignored: got %h expected %h", obs(), e);
    end
    tmr_finish = 1'b0;
    tick();
    tick();
    tick();
    tmr_finish = 1'b1;
    tick();
    e = ex(AUTO, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0, AUTO ? 16'h0500 : 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL finish_edge_done: got %h expected %h", obs(), e);
    end
    tmr_finish = 1'b0;
    advance(2'd2, 3'd1, 16'h0500, "short_load_after_edge");
  endtask

  task automatic test_session();
    do_reset();
    pulse_start();
    tick();
    fin_pulse();
    e = ex(AUTO, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0, AUTO ? 16'h0500 : 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL work1_done: got %h expected %h", obs(), e);
    end
    advance(2'd2, 3'd1, 16'h0500, "short_load");
    fin_pulse();
    e = ex(AUTO, 1'b0, 2'd1, 3'd1, 1'b1, 1'b0, AUTO ? 16'h2500 : 16'h0500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL short_done: got %h expected %h", obs(), e);
    end
    advance(2'd1, 3'd1, 16'h2500, "work2_load");
    fin_pulse();
    e = ex(AUTO, 1'b0, 2'd3, 3'd2, 1'b1, 1'b0, AUTO ? 16'h1500 : 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL work2_done: got %h expected %h", obs(), e);
    end
    advance(2'd3, 3'd2, 16'h1500, "long_load");
    fin_pulse();
    e = ex(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 16'h1500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL long_done: got %h expected %h", obs(), e);
    end
    tick();
    e = ex(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 16'h1500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL session_pulse_width: got %h expected %h", obs(), e);
    end
    skip = 1'b1;
    pause = 1'b1;
    tick();
    skip = 1'b0;
    pause = 1'b0;
    tick();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL idle_ignores_inputs: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_start();
    tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    e = ex(1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_stops_run: got %h expected %h", obs(), e);
    end
    tick();
    tmr_finish = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL pause_ignores_finish: got %h expected %h", obs(), e);
    end
    tmr_finish = 1'b0;
    tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    e = ex(1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL resume_run: got %h expected %h", obs(), e);
    end
    skip = 1'b1;
    tick();
    skip = 1'b0;
    e = ex(AUTO, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0, AUTO ? 16'h0500 : 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL skip_done: got %h expected %h", obs(), e);
    end
  endtask

  // Continues from the HOLD left by test_pause.
  task automatic test_hold();
    tick();
    pause = 1'b1;
    skip = 1'b1;
    tick();
    pause = 1'b0;
    skip = 1'b0;
    e = ex(1'b0, 1'b0, 2'd2, 3'd1, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL hold_ignores_pause_skip: got %h expected %h", obs(), e);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    e = '0;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL hold_abort_wins: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_abort();
    do_reset();
    pulse_start();
    tick();
    abort = 1'b1;
    skip = 1'b1;
    tick();
    abort = 1'b0;
    skip = 1'b0;
    e = '0;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_over_skip: got %h expected %h", obs(), e);
    end
    tick();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_no_pulse: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    tick();
    tick();
    tmr_finish = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = '0;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_mid_run: got %h expected %h", obs(), e);
    end
    tick();
    pulse_start();
    e = ex(1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL restart_load: got %h expected %h", obs(), e);
    end
    tick();
    tick();
    e = ex(1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 16'h2500);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL restart_no_stale_done: got %h expected %h", obs(), e);
    end
    tmr_finish = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_stale_finish();
    test_session();
    test_pause();
`ifndef AUTO_ADVANCE_EN
    test_hold();
`endif
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
